// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU data port, host/debug port and single-port dmem signals shared by dmem_arbiter.
// master = requesters plus memory model side, slave = the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic [3:0]        host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [31:0]       host_wdata;
    logic [31:0]       host_rdata;
    logic              host_ack;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous dmem between CPU (priority) and host port, with bounded host wait.
// Optional macro DMEM_ARB_STATS_EN enables the saturating conflict_cnt_o statistics counter.
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus,
    output logic [15:0]   conflict_cnt_o
);
    typedef enum logic [0:0] {
        ARB      = 1'b0,
        HOST_ACK = 1'b1
    } state_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic              host_seen_s;
    logic              host_win_s;
    logic              mem_en_s;
    logic [3:0]        mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s;
    logic              cpu_stall_s;

    // FSM state and host wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Grant decision, next state and memory port mux
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        host_seen_s = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 4'd0;
        mem_addr_s  = bus.cpu_addr;
        mem_wdata_s = bus.cpu_wdata;
        cpu_stall_s = 1'b0;

        case (state_q)
            ARB: begin
                host_seen_s = bus.host_req;
                state_d     = ARB;
            end
            HOST_ACK: begin
                // host_req is still held during the ack cycle and must not re-grant
                host_seen_s = 1'b0;
                state_d     = ARB;
            end
            default: begin
                host_seen_s = 1'b0;
                state_d     = ARB;
            end
        endcase

        host_win_s = host_seen_s && (!bus.cpu_req || (wait_q >= MAX_WAIT_C));

        if (host_win_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.host_we;
            mem_addr_s  = bus.host_addr;
            mem_wdata_s = bus.host_wdata;
            cpu_stall_s = bus.cpu_req;
            state_d     = HOST_ACK;
            wait_d      = 8'd0;
        end else if (bus.cpu_req) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.cpu_we;
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
            cpu_stall_s = 1'b0;
            if (host_seen_s && (wait_q != 8'hFF)) begin
                wait_d = wait_q + 8'd1;
            end else begin
                wait_d = wait_q;
            end
        end else begin
            mem_en_s = 1'b0;
            mem_we_s = 4'd0;
        end
    end

    // Memory strobes and stall are forced quiet while reset is asserted
    assign bus.mem_en     = mem_en_s & rst_n;
    assign bus.mem_we     = mem_we_s & {4{rst_n}};
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.cpu_stall  = cpu_stall_s & rst_n;
    assign bus.host_ack   = (state_q == HOST_ACK);
    assign bus.host_rdata = bus.mem_rdata;
    assign bus.cpu_rdata  = bus.mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_q;

    // Saturating count of cycles where both ports request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 16'h0000;
        end else if (bus.cpu_req && bus.host_req && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end else begin
            conflict_q <= conflict_q;
        end
    end

    assign conflict_cnt_o = conflict_q;
`else
    assign conflict_cnt_o = 16'h0000;
`endif
endmodule
